// File: rtl/uart_packet_parser_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_packet_parser_if : UART-RX pop handshake plus validated payload stream |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface uart_packet_parser_if;
   logic       pending_data_rx;
   logic       req_data;
   logic [7:0] data_out_rx;
   logic       parity_error_rx;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       pkt_ok;
   logic       pkt_err;
   logic [1:0] err_code;

   modport master (
      input  pending_data_rx, data_out_rx, parity_error_rx, out_ready,
      output req_data, out_valid, out_data, out_last, pkt_ok, pkt_err, err_code
   );

   modport slave (
      output pending_data_rx, data_out_rx, parity_error_rx, out_ready,
      input  req_data, out_valid, out_data, out_last, pkt_ok, pkt_err, err_code
   );
endinterface
`default_nettype wire

// File: rtl/uart_packet_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_packet_parser : frames SYNC/LEN/PAYLOAD/CHK packets from the UART RX  |
// | FIFO and streams checksum-validated payload. Option: UART_PKT_TIMEOUT_EN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_packet_parser #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_PAYLOAD    = 16,
   parameter int         TIMEOUT_CYCLES = 120000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   uart_packet_parser_if.master bus
);
   localparam int         IW      = $clog2(MAX_PAYLOAD + 1);
   localparam int         DEPTH   = 1 << IW;
   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_CHK     = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;

   state_t        state_q;
   logic [1:0]    fcnt_q;
   logic          req_q;
   logic [7:0]    len_q;
   logic [7:0]    chk_q;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] rd_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic [7:0]    out_data_q;
   logic          pkt_ok_q;
   logic          pkt_err_q;
   logic [1:0]    err_code_q;
   logic [7:0]    mem_q [DEPTH];

   logic          w_byte_evt;
   logic          w_in_pkt;
   logic          w_tmo_expire;
   logic          w_mem_we;
   logic [7:0]    w_idx_nxt;
   logic [IW-1:0] w_rd_nxt;

   // fcnt_q = 3 is the cycle two after req_data, when the popped byte is valid
   assign w_byte_evt = (fcnt_q == 2'd3);
   assign w_in_pkt   = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
   assign w_idx_nxt  = 8'(idx_q) + 8'd1;
   assign w_rd_nxt   = rd_q + IW'(1);
   assign w_mem_we   = w_byte_evt && (state_q == ST_PAYLOAD) && !bus.parity_error_rx;

`ifdef UART_PKT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_q;

   assign w_tmo_expire = w_in_pkt && (fcnt_q == 2'd0) && (tmo_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
      end else if (w_byte_evt || !w_in_pkt) begin
         tmo_q <= '0;
      end else if (fcnt_q == 2'd0) begin
         tmo_q <= tmo_q + CW'(1);
      end
   end
`else
   // Constant 0: a stalled packet simply waits for more bytes
   assign w_tmo_expire = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem_q[idx_q] <= bus.data_out_rx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_HUNT;
         fcnt_q      <= 2'd0;
         req_q       <= 1'b0;
         len_q       <= 8'd0;
         chk_q       <= 8'd0;
         idx_q       <= '0;
         rd_q        <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= 8'd0;
         pkt_ok_q    <= 1'b0;
         pkt_err_q   <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         pkt_ok_q  <= 1'b0;
         pkt_err_q <= 1'b0;

         // Fetch: a 4-cycle req/wait/wait/sample loop, never started in DRAIN
         if (fcnt_q != 2'd0) begin
            fcnt_q <= fcnt_q + 2'd1;
            req_q  <= 1'b0;
         end else if (bus.pending_data_rx && (state_q != ST_DRAIN)) begin
            fcnt_q <= 2'd1;
            req_q  <= 1'b1;
         end else begin
            req_q  <= 1'b0;
         end

         case (state_q)
            ST_HUNT: begin
               if (w_byte_evt && !bus.parity_error_rx && (bus.data_out_rx == SYNC_BYTE)) begin
                  state_q <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (w_byte_evt) begin
                  len_q <= bus.data_out_rx;
                  chk_q <= bus.data_out_rx;
                  idx_q <= '0;
                  if (bus.parity_error_rx) begin
                     pkt_err_q  <= 1'b1;
                     err_code_q <= 2'b01;
                     state_q    <= ST_HUNT;
                  end else if (bus.data_out_rx > MAX_LEN) begin
                     pkt_err_q  <= 1'b1;
                     err_code_q <= 2'b10;
                     state_q    <= ST_HUNT;
                  end else if (bus.data_out_rx == 8'd0) begin
                     state_q <= ST_CHK;
                  end else begin
                     state_q <= ST_PAYLOAD;
                  end
               end else if (w_tmo_expire) begin
                  pkt_err_q  <= 1'b1;
                  err_code_q <= 2'b00;
                  state_q    <= ST_HUNT;
               end
            end
            ST_PAYLOAD: begin
               if (w_byte_evt) begin
                  if (bus.parity_error_rx) begin
                     pkt_err_q  <= 1'b1;
                     err_code_q <= 2'b01;
                     state_q    <= ST_HUNT;
                  end else begin
                     chk_q <= chk_q ^ bus.data_out_rx;
                     idx_q <= idx_q + IW'(1);
                     if (w_idx_nxt == len_q) begin
                        state_q <= ST_CHK;
                     end
                  end
               end else if (w_tmo_expire) begin
                  pkt_err_q  <= 1'b1;
                  err_code_q <= 2'b00;
                  state_q    <= ST_HUNT;
               end
            end
            ST_CHK: begin
               if (w_byte_evt) begin
                  if (bus.parity_error_rx) begin
                     pkt_err_q  <= 1'b1;
                     err_code_q <= 2'b01;
                     state_q    <= ST_HUNT;
                  end else if (bus.data_out_rx == chk_q) begin
                     pkt_ok_q <= 1'b1;
                     if (len_q == 8'd0) begin
                        state_q <= ST_HUNT;
                     end else begin
                        // First beat is presented together with the pkt_ok pulse
                        state_q     <= ST_DRAIN;
                        rd_q        <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= mem_q['0];
                        out_last_q  <= (len_q == 8'd1);
                     end
                  end else begin
                     pkt_err_q  <= 1'b1;
                     err_code_q <= 2'b11;
                     state_q    <= ST_HUNT;
                  end
               end else if (w_tmo_expire) begin
                  pkt_err_q  <= 1'b1;
                  err_code_q <= 2'b00;
                  state_q    <= ST_HUNT;
               end
            end
            ST_DRAIN: begin
               if (out_valid_q && bus.out_ready) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     state_q     <= ST_HUNT;
                  end else begin
                     rd_q       <= w_rd_nxt;
                     out_data_q <= mem_q[w_rd_nxt];
                     out_last_q <= ((8'(rd_q) + 8'd2) == len_q);
                  end
               end
            end
            default: begin
               state_q <= ST_HUNT;
            end
         endcase
      end
   end

   assign bus.req_data  = req_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.pkt_ok    = pkt_ok_q;
   assign bus.pkt_err   = pkt_err_q;
   assign bus.err_code  = err_code_q;
endmodule
`default_nettype wire
